// File: rtl/nx_ram_access.sv
// nx_ram_access: valid/ready front-end for one nx_ram port with credit-guarded response FIFO.
// Define NX_RAM_ACCESS_WR_ACK_EN to return an in-order acknowledgement for every accepted write.
module nx_ram_access #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int RD_LATENCY    = 1,
    parameter int RSP_DEPTH     = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [ADDRESS_WIDTH-1:0]  i_req_addr,
    input  logic [DATA_WIDTH-1:0]     i_req_wr_data,
    input  logic [DATA_WIDTH/8-1:0]   i_req_wr_strb,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    output logic [ADDRESS_WIDTH-1:0]  o_ram_addr,
    output logic [DATA_WIDTH-1:0]     o_ram_wr_data,
    output logic [DATA_WIDTH/8-1:0]   o_ram_wr_en,
    output logic                      o_ram_en,
    input  logic [DATA_WIDTH-1:0]     i_ram_rd_data,
    output logic [DATA_WIDTH-1:0]     o_rsp_data,
    output logic                      o_rsp_write,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready
);
    localparam int PW = $clog2(RSP_DEPTH) + 1;
    localparam int IW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] PTR_HALF = PW'(RSP_DEPTH);
    localparam logic [PW-1:0] PTR_MAX  = PW'(2 * RSP_DEPTH - 1);

    logic                  is_rd, accept, take, push, pop, empty;
    logic [CW-1:0]         cnt;
    logic [RD_LATENCY-1:0] pipe_v;
    logic [PW-1:0]         wr_ptr, rd_ptr, wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign is_rd = ~|i_req_wr_strb;
`ifdef NX_RAM_ACCESS_WR_ACK_EN
    logic [RD_LATENCY-1:0] pipe_w;
    logic                  mem_w [RSP_DEPTH];
    assign o_req_ready = i_rst_n & (cnt < DEPTH_C);
    assign take        = accept;
    assign o_rsp_write = ~empty & mem_w[rd_idx[IW-1:0]];
`else
    assign o_req_ready = i_rst_n & (~is_rd | (cnt < DEPTH_C));
    assign take        = accept & is_rd;
    assign o_rsp_write = 1'b0;
`endif
    assign accept        = i_req_valid & o_req_ready;
    assign o_ram_en      = accept;
    assign o_ram_addr    = i_req_addr;
    assign o_ram_wr_data = i_req_wr_data;
    assign o_ram_wr_en   = accept ? i_req_wr_strb : '0;

    assign push        = pipe_v[RD_LATENCY-1];
    assign empty       = wr_ptr == rd_ptr;
    assign o_rsp_valid = ~empty;
    assign pop         = o_rsp_valid & i_rsp_ready;
    assign wr_idx      = (wr_ptr >= PTR_HALF) ? wr_ptr - PTR_HALF : wr_ptr;
    assign rd_idx      = (rd_ptr >= PTR_HALF) ? rd_ptr - PTR_HALF : rd_ptr;
    assign o_rsp_data  = empty ? '0 : mem_d[rd_idx[IW-1:0]];

    // Credits cover everything in the pipe plus the FIFO, so a push never finds the FIFO full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            pipe_v <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
`ifdef NX_RAM_ACCESS_WR_ACK_EN
            pipe_w <= '0;
`endif
        end else begin
            cnt       <= cnt + CW'(take) - CW'(pop);
            pipe_v[0] <= take;
            for (int i = 1; i < RD_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
`ifdef NX_RAM_ACCESS_WR_ACK_EN
            pipe_w[0] <= accept & ~is_rd;
            for (int i = 1; i < RD_LATENCY; i++) pipe_w[i] <= pipe_w[i-1];
`endif
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop) rd_ptr <= next_ptr(rd_ptr);
        end
    end

    always_ff @(posedge i_clk) begin
`ifdef NX_RAM_ACCESS_WR_ACK_EN
        if (push) begin
            mem_d[wr_idx[IW-1:0]] <= pipe_w[RD_LATENCY-1] ? '0 : i_ram_rd_data;
            mem_w[wr_idx[IW-1:0]] <= pipe_w[RD_LATENCY-1];
        end
`else
        if (push) mem_d[wr_idx[IW-1:0]] <= i_ram_rd_data;
`endif
    end
endmodule

// File: tb/tb_nx_ram_access.sv
// tb_nx_ram_access: directed tests of nx_ram_access against a 1-cycle byte-write RAM model.
module tb_nx_ram_access;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wr_data = '0;
    logic [SW-1:0] req_wr_strb = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic [SW-1:0] ram_wr_en;
    logic          ram_en;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] rsp_data;
    logic          rsp_write;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nx_ram_access #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .RSP_DEPTH(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_addr(req_addr), .i_req_wr_data(req_wr_data), .i_req_wr_strb(req_wr_strb),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .o_ram_addr(ram_addr), .o_ram_wr_data(ram_wr_data), .o_ram_wr_en(ram_wr_en),
        .o_ram_en(ram_en), .i_ram_rd_data(ram_rd_data),
        .o_rsp_data(rsp_data), .o_rsp_write(rsp_write), .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready)
    );

    // RAM model: unwritten words read back a fixed address-derived pattern
    logic [DW-1:0] ram [1 << AW];
    bit            written [1 << AW];
    logic [DW-1:0] cur;

    function automatic logic [DW-1:0] init_val(input int a);
        return 32'hC0DE0000 + 32'(a) * 32'h00000101;
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_en != '0) begin
                cur = written[ram_addr] ? ram[ram_addr] : init_val(int'(ram_addr));
                for (int b = 0; b < SW; b++) if (ram_wr_en[b]) cur[b*8 +: 8] = ram_wr_data[b*8 +: 8];
                ram[ram_addr]     <= cur;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rd_data <= written[ram_addr] ? ram[ram_addr] : init_val(int'(ram_addr));
            end
        end
    end

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_valid   = v;
        req_addr    = a;
        req_wr_data = d;
        req_wr_strb = s;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        int acks, exp_acks;
        @(negedge clk);
        drive(1'b1, a, d, s);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", req_ready); end
        checks++;
        if (ram_wr_en !== s) begin errors++; $display("FAIL wr_strobe: got %h want %h", ram_wr_en, s); end
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b0, '0, '0, '0);
            #1;
            if (rsp_valid) begin
                acks++;
                checks++;
                if (rsp_write !== 1'b1 || rsp_data !== '0) begin
                    errors++;
                    $display("FAIL wr_ack: got write=%b data=%h want write=1 data=0", rsp_write, rsp_data);
                end
            end
        end
`ifdef NX_RAM_ACCESS_WR_ACK_EN
        exp_acks = 1;
`else
        exp_acks = 0;
`endif
        checks++;
        if (acks != exp_acks) begin errors++; $display("FAIL wr_ack_count: got %0d want %0d", acks, exp_acks); end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        checks++;
        if (rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        checks++;
        if (rsp_write !== 1'b0) begin errors++; $display("FAIL rst_rsp_write: got %b want 0", rsp_write); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        rsp_ready = 1'b1;
        write_word(10'd5, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        drive(1'b1, 10'd5, '0, '0);
        #1;
        checks++;
        if (req_ready !== 1'b1 || ram_en !== 1'b1 || ram_wr_en !== '0) begin
            errors++;
            $display("FAIL rd_issue: got ready=%b en=%b wr_en=%h want 1 1 0", req_ready, ram_en, ram_wr_en);
        end
        @(negedge clk);
        drive(1'b0, 10'd5, 32'h1, 4'hF);
        #1;
        checks++;
        if (ram_en !== 1'b0 || ram_wr_en !== '0) begin
            errors++;
            $display("FAIL idle_strobe: got en=%b wr_en=%h want 0 0", ram_en, ram_wr_en);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_early: got valid=%b want 0", rsp_valid); end
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_write !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: got valid=%b data=%h write=%b want 1 deadbeef 0", rsp_valid, rsp_data, rsp_write);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pop: got valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_partial_write;
        bit got;
        write_word(10'd5, 32'h0000AB00, 4'b0010);
        @(negedge clk);
        drive(1'b1, 10'd5, '0, '0);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            drive(1'b0, '0, '0, '0);
            #1;
            if (rsp_valid) begin
                got = 1;
                checks++;
                if (rsp_data !== 32'hDEADABEF) begin errors++; $display("FAIL partial: got %h want deadabef", rsp_data); end
            end
        end
        if (!got) begin errors++; checks++; $display("FAIL partial_timeout: got no response want 1"); end
    endtask

    task automatic test_back_to_back;
        rsp_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (c < 16) drive(1'b1, AW'(100 + c), '0, '0); else drive(1'b0, '0, '0, '0);
            #1;
            if (c < 16) begin
                checks++;
                if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_stall c=%0d: got ready=%b want 1", c, req_ready); end
            end
            checks++;
            if (rsp_valid !== (c >= 2 && c < 18)) begin
                errors++;
                $display("FAIL b2b_valid c=%0d: got %b want %b", c, rsp_valid, (c >= 2 && c < 18));
            end
            if (rsp_valid && c >= 2) begin
                checks++;
                if (rsp_data !== init_val(100 + c - 2)) begin
                    errors++;
                    $display("FAIL b2b_data c=%0d: got %h want %h", c, rsp_data, init_val(100 + c - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int acc, nrx;
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(1'b1, AW'(200 + acc), '0, '0);
            #1;
            if (req_ready) acc++;
        end
        checks++;
        if (acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", acc); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", req_ready); end
        nrx = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            if (c < 2) drive(1'b1, AW'(204), '0, '0); else drive(1'b0, '0, '0, '0);
            #1;
            if (c == 0) begin
                checks++;
                if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_credit: got ready=%b want 0", req_ready); end
            end
            if (c == 1) begin
                checks++;
                if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen: got ready=%b want 1", req_ready); end
            end
            if (rsp_valid) begin
                checks++;
                if (rsp_data !== init_val(200 + nrx)) begin
                    errors++;
                    $display("FAIL bp_order n=%0d: got %h want %h", nrx, rsp_data, init_val(200 + nrx));
                end
                nrx++;
            end
        end
        checks++;
        if (nrx != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", nrx); end
    endtask

    task automatic test_reset_midflight;
        int stale;
        bit got;
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, AW'(300 + c), '0, '0);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill: got valid=%b want 1", rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b ready=%b data=%h want 0 0 0", rsp_valid, req_ready, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL mid_stale: got %0d responses want 0", stale); end
        @(negedge clk);
        drive(1'b1, AW'(310), '0, '0);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            drive(1'b0, '0, '0, '0);
            #1;
            if (rsp_valid) begin
                got = 1;
                checks++;
                if (rsp_data !== init_val(310)) begin
                    errors++;
                    $display("FAIL mid_after: got %h want %h", rsp_data, init_val(310));
                end
            end
        end
        if (!got) begin errors++; checks++; $display("FAIL mid_after_timeout: got no response want 1"); end
    endtask

`ifdef NX_RAM_ACCESS_WR_ACK_EN
    task automatic test_wr_ack;
        int nrx;
        rsp_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, AW'(400), 32'h12345678, 4'hF);
        @(negedge clk);
        drive(1'b1, AW'(400), '0, '0);
        nrx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(1'b0, '0, '0, '0);
            #1;
            if (rsp_valid) begin
                checks++;
                if (nrx == 0 && (rsp_write !== 1'b1 || rsp_data !== '0)) begin
                    errors++;
                    $display("FAIL ack_first: got write=%b data=%h want 1 0", rsp_write, rsp_data);
                end
                if (nrx == 1 && (rsp_write !== 1'b0 || rsp_data !== 32'h12345678)) begin
                    errors++;
                    $display("FAIL ack_second: got write=%b data=%h want 0 12345678", rsp_write, rsp_data);
                end
                nrx++;
            end
        end
        checks++;
        if (nrx != 2) begin errors++; $display("FAIL ack_count: got %0d want 2", nrx); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef NX_RAM_ACCESS_WR_ACK_EN
        test_wr_ack();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
